// File: rtl/if_id_elastic_stage_pkg.sv
`default_nettype none
// ============================================================================
// if_id_elastic_stage_pkg : opcodes, field positions and pre-decode record
// Revision 1.0
// ============================================================================
package if_id_elastic_stage_pkg;

  // 12-bit opcode = {major opcode, funct-or-zero}
  localparam logic [11:0] OPC_SLL = 12'h000;
  localparam logic [11:0] OPC_SRL = 12'h002;
  localparam logic [11:0] OPC_JAL = 12'h0C0;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  typedef struct packed {
    logic [11:0] opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } predec_t;

endpackage
`default_nettype wire

// File: rtl/if_id_elastic_stage_predecode.sv
`default_nettype none
// ============================================================================
// if_id_predecode : combinational instruction word -> opcode/register indices
// Revision 1.0
// ============================================================================
module if_id_predecode
  import if_id_elastic_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RA_IDX = 31
) (
  input  logic [XLEN-1:0] inst,
  output predec_t         dec
);

  logic [5:0]  major;
  logic        is_rfmt;
  logic [11:0] opcode;
  logic        unused_shamt;

  assign major   = inst[OP_HI:OP_LO];
  assign is_rfmt = (major == 6'd0);
  assign opcode  = {major, is_rfmt ? inst[FUNCT_HI:FUNCT_LO] : 6'd0};
  assign unused_shamt = ^inst[SHAMT_HI:SHAMT_LO];

  always_comb begin
    dec        = '0;
    dec.opcode = opcode;
    dec.rs2    = inst[RT_HI:RT_LO];
    // Shifts read their operand from the rt field
    dec.rs1    = (opcode == OPC_SLL || opcode == OPC_SRL) ? inst[RT_HI:RT_LO]
                                                          : inst[RS_HI:RS_LO];
    if (is_rfmt)
      dec.rd = inst[RD_HI:RD_LO];
    else if (opcode == OPC_JAL)
      dec.rd = 5'(RA_IDX);
    else
      dec.rd = inst[RT_HI:RT_LO];
  end

endmodule
`default_nettype wire

// File: rtl/if_id_elastic_stage.sv
`default_nettype none
// ============================================================================
// if_id_elastic_stage : DEPTH-entry valid/ready FIFO between fetch and decode
// Revision 1.0
// ============================================================================
module if_id_elastic_stage
  import if_id_elastic_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 2,
  parameter int RA_IDX = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [PC_W-1:0]          if_pc,
  input  logic [XLEN-1:0]          if_inst,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [PC_W-1:0]          id_pc,
  output logic [XLEN-1:0]          id_inst,
  output logic [11:0]              id_opcode,
  output logic [4:0]               id_rs1_ind,
  output logic [4:0]               id_rs2_ind,
  output logic [4:0]               id_rd_ind,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  pc_q   [DEPTH];
  logic [XLEN-1:0]  inst_q [DEPTH];
  predec_t          dec_q  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  predec_t          wr_dec;
  predec_t          head_dec;
  logic             push;
  logic             pop;

  if_id_predecode #(
    .XLEN   (XLEN),
    .RA_IDX (RA_IDX)
  ) u_predecode (
    .inst (if_inst),
    .dec  (wr_dec)
  );

  // No pass-through when full: if_ready depends on count only
  assign if_ready = (count != CNT_W'(DEPTH));
  assign id_valid = (count != '0);
  assign push     = if_valid && if_ready && !flush;
  assign pop      = id_valid && id_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
        dec_q[i]  <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]   <= if_pc;
        inst_q[wr_ptr] <= if_inst;
        dec_q[wr_ptr]  <= wr_dec;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Empty stage presents an all-zero bubble to decode
  assign head_dec   = dec_q[rd_ptr];
  assign id_pc      = id_valid ? pc_q[rd_ptr]   : '0;
  assign id_inst    = id_valid ? inst_q[rd_ptr] : '0;
  assign id_opcode  = id_valid ? head_dec.opcode : '0;
  assign id_rs1_ind = id_valid ? head_dec.rs1    : '0;
  assign id_rs2_ind = id_valid ? head_dec.rs2    : '0;
  assign id_rd_ind  = id_valid ? head_dec.rd     : '0;
  assign occupancy  = count;

endmodule
`default_nettype wire

// File: tb/tb_if_id_elastic_stage.sv
`default_nettype none
// ============================================================================
// tb_if_id_elastic_stage : directed self-checking bench for the IF/ID FIFO
// Revision 1.0
// ============================================================================
module tb_if_id_elastic_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [11:0] id_opcode;
  logic [4:0]  id_rs1_ind;
  logic [4:0]  id_rs2_ind;
  logic [4:0]  id_rd_ind;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  if_id_elastic_stage #(
    .XLEN(32), .PC_W(32), .DEPTH(2), .RA_IDX(31)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .id_opcode(id_opcode), .id_rs1_ind(id_rs1_ind), .id_rs2_ind(id_rs2_ind),
    .id_rd_ind(id_rd_ind), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if ({id_valid, if_ready, occupancy} !== {1'b0, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_flags: got v=%b r=%b occ=%0d, want v=0 r=1 occ=0", id_valid, if_ready, occupancy);
    end
    n_checks++;
    if ({id_pc, id_inst, id_opcode, id_rs1_ind, id_rs2_ind, id_rd_ind} !== 71'd0) begin
      n_fail++;
      $display("FAIL reset_data: got pc=%h inst=%h opc=%h, want all zero", id_pc, id_inst, id_opcode);
    end
  endtask

  task automatic test_single();
    id_ready = 1'b1; if_valid = 1'b1; if_pc = 32'h100; if_inst = 32'h00221820;
    step();
    if_valid = 1'b0;
    n_checks++;
    if ({id_valid, id_pc, id_opcode, id_rs1_ind, id_rs2_ind, id_rd_ind} !==
        {1'b1, 32'h100, 12'h020, 5'd1, 5'd2, 5'd3}) begin
      n_fail++;
      $display("FAIL single_add: got v=%b pc=%h opc=%h rs1=%0d rs2=%0d rd=%0d, want v=1 pc=100 opc=020 1/2/3",
               id_valid, id_pc, id_opcode, id_rs1_ind, id_rs2_ind, id_rd_ind);
    end
    step();
    n_checks++;
    if ({id_valid, occupancy, id_pc, id_inst, id_opcode, id_rs1_ind, id_rs2_ind, id_rd_ind} !== 74'd0) begin
      n_fail++;
      $display("FAIL single_drain: got v=%b occ=%0d pc=%h inst=%h, want all zero", id_valid, occupancy, id_pc, id_inst);
    end
  endtask

  task automatic test_predecode();
    logic [31:0] insts [3];
    logic [26:0] exp   [3];
    insts[0] = 32'h00052080; exp[0] = {12'h000, 5'd5, 5'd5, 5'd4};
    insts[1] = 32'h0C000010; exp[1] = {12'h0C0, 5'd0, 5'd0, 5'd31};
    insts[2] = 32'h20280005; exp[2] = {12'h200, 5'd1, 5'd8, 5'd8};
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_valid = 1'b1; if_pc = 32'h300 + 32'(4 * i); if_inst = insts[i];
      step();
      if_valid = 1'b0;
      n_checks++;
      if ({id_valid, id_inst, id_opcode, id_rs1_ind, id_rs2_ind, id_rd_ind} !== {1'b1, insts[i], exp[i]}) begin
        n_fail++;
        $display("FAIL predecode_%0d: got v=%b opc=%h rs1=%0d rs2=%0d rd=%0d, want opc=%h rs1=%0d rs2=%0d rd=%0d",
                 i, id_valid, id_opcode, id_rs1_ind, id_rs2_ind, id_rd_ind,
                 exp[i][26:15], exp[i][14:10], exp[i][9:5], exp[i][4:0]);
      end
      step();
    end
  endtask

  task automatic test_full();
    id_ready = 1'b0;
    if_valid = 1'b1; if_pc = 32'h200; if_inst = 32'hA0000001;
    step();
    if_pc = 32'h204; if_inst = 32'hA0000002;
    step();
    n_checks++;
    if ({if_ready, occupancy, id_pc} !== {1'b0, 2'd2, 32'h200}) begin
      n_fail++;
      $display("FAIL full_after_two: got r=%b occ=%0d pc=%h, want r=0 occ=2 pc=200", if_ready, occupancy, id_pc);
    end
    if_pc = 32'h208; if_inst = 32'hA0000003;
    step();
    n_checks++;
    if ({if_ready, occupancy, id_pc} !== {1'b0, 2'd2, 32'h200}) begin
      n_fail++;
      $display("FAIL full_hold: got r=%b occ=%0d pc=%h, want r=0 occ=2 pc=200", if_ready, occupancy, id_pc);
    end
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    n_checks++;
    if ({if_ready, occupancy, id_pc, id_inst} !== {1'b1, 2'd1, 32'h204, 32'hA0000002}) begin
      n_fail++;
      $display("FAIL full_pop: got r=%b occ=%0d pc=%h, want r=1 occ=1 pc=204", if_ready, occupancy, id_pc);
    end
    step();
    if_valid = 1'b0;
    n_checks++;
    if ({if_ready, occupancy, id_pc} !== {1'b0, 2'd2, 32'h204}) begin
      n_fail++;
      $display("FAIL full_refill: got r=%b occ=%0d pc=%h, want r=0 occ=2 pc=204", if_ready, occupancy, id_pc);
    end
    id_ready = 1'b1;
    step();
    n_checks++;
    if ({occupancy, id_pc, id_inst} !== {2'd1, 32'h208, 32'hA0000003}) begin
      n_fail++;
      $display("FAIL full_order: got occ=%0d pc=%h inst=%h, want occ=1 pc=208 inst=a0000003", occupancy, id_pc, id_inst);
    end
    step();
    n_checks++;
    if ({id_valid, occupancy} !== 3'd0) begin
      n_fail++;
      $display("FAIL full_drain: got v=%b occ=%0d, want v=0 occ=0", id_valid, occupancy);
    end
  endtask

  task automatic test_back_to_back();
    id_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if_valid = 1'b1; if_pc = 32'(4 * i); if_inst = 32'h20000000 | 32'(i);
      step();
      n_checks++;
      if ({id_valid, occupancy, id_pc, id_inst} !== {1'b1, 2'd1, 32'(4 * i), 32'h20000000 | 32'(i)}) begin
        n_fail++;
        $display("FAIL b2b_%0d: got v=%b occ=%0d pc=%h inst=%h, want v=1 occ=1 pc=%h",
                 i, id_valid, occupancy, id_pc, id_inst, 4 * i);
      end
    end
    if_valid = 1'b0;
    step();
    n_checks++;
    if ({id_valid, occupancy} !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_drain: got v=%b occ=%0d, want v=0 occ=0", id_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    id_ready = 1'b0;
    if_valid = 1'b1; if_pc = 32'h400; if_inst = 32'hB0000001;
    step();
    if_pc = 32'h404; if_inst = 32'hB0000002;
    step();
    flush = 1'b1; if_pc = 32'h408; if_inst = 32'hB0000003;
    step();
    flush = 1'b0; if_valid = 1'b0;
    n_checks++;
    if ({id_valid, if_ready, occupancy, id_inst} !== {1'b0, 1'b1, 2'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL flush_full: got v=%b r=%b occ=%0d inst=%h, want v=0 r=1 occ=0", id_valid, if_ready, occupancy, id_inst);
    end
    // One entry: the same-cycle push must be discarded too
    if_valid = 1'b1; if_pc = 32'h500; if_inst = 32'hC0000001;
    step();
    flush = 1'b1; if_pc = 32'h504; if_inst = 32'hC0000002;
    step();
    flush = 1'b0; if_valid = 1'b0;
    n_checks++;
    if ({id_valid, if_ready, occupancy} !== {1'b0, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL flush_push: got v=%b r=%b occ=%0d, want v=0 r=1 occ=0", id_valid, if_ready, occupancy);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++;
    if ({id_valid, if_ready, occupancy} !== {1'b0, 1'b1, 2'd0}) begin
      n_fail++;
      $display("FAIL flush_empty: got v=%b r=%b occ=%0d, want v=0 r=1 occ=0", id_valid, if_ready, occupancy);
    end
    id_ready = 1'b1; if_valid = 1'b1; if_pc = 32'h600; if_inst = 32'hD0000001;
    step();
    if_valid = 1'b0;
    n_checks++;
    if ({id_valid, occupancy, id_pc} !== {1'b1, 2'd1, 32'h600}) begin
      n_fail++;
      $display("FAIL flush_resume: got v=%b occ=%0d pc=%h, want v=1 occ=1 pc=600", id_valid, occupancy, id_pc);
    end
    step();
  endtask

  task automatic test_async_reset();
    id_ready = 1'b0; if_valid = 1'b1; if_pc = 32'h700; if_inst = 32'h00221820;
    step();
    if_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({id_valid, occupancy, id_pc, id_inst, id_opcode, id_rd_ind} !== 84'd0) begin
      n_fail++;
      $display("FAIL async_rst: got v=%b occ=%0d pc=%h inst=%h, want all zero", id_valid, occupancy, id_pc, id_inst);
    end
    #2 rst = 1'b0;
    id_ready = 1'b1; if_valid = 1'b1; if_pc = 32'h800; if_inst = 32'h0C000010;
    step();
    if_valid = 1'b0;
    n_checks++;
    if ({id_valid, occupancy, id_pc, id_opcode, id_rd_ind} !== {1'b1, 2'd1, 32'h800, 12'h0C0, 5'd31}) begin
      n_fail++;
      $display("FAIL post_rst_push: got v=%b occ=%0d pc=%h opc=%h rd=%0d, want v=1 occ=1 pc=800 opc=0c0 rd=31",
               id_valid, occupancy, id_pc, id_opcode, id_rd_ind);
    end
    step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; id_ready = 1'b0;
    test_reset();
    test_single();
    test_predecode();
    test_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
